contador_sched: RTL and testbench
=================================

# contador_sched

Round-robin scheduler that shares one 4-bit `contador` counter between two requesters. Each granted requester gets a load of its preset value, then a run phase in its chosen mode until a requested number of `rco` pulses is observed. A watchdog aborts runs that never complete. The block sits between the requesters and the counter's `enable`/`mode`/`D` inputs and observes the counter's `rco`.

## Interface

Parameters:
- `LOAD_MODE`, default 2'b11: `cnt_mode` code that makes the counter load `cnt_D`.
- `TIMEOUT`, default 64: maximum cycles spent in RUN before abort (range 2..255).

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req0`, `req1`  in  1 each  request lines; held until `done[i]`.
- `mode0`, `mode1`  in  2 each  counting mode for the run phase.
- `d0`, `d1`  in  4 each  preset value loaded before the run.
- `n0`, `n1`  in  4 each  number of `rco` pulses to wait for; 0 means load only.
- `cnt_rco`  in  1  counter ripple-carry-out.
- `cnt_enable`  out  1  counter enable.
- `cnt_mode`  out  2  counter mode.
- `cnt_D`  out  4  counter preset data.
- `grant`  out  2  one-hot owner of the counter; 2'b00 when idle.
- `done`  out  2  one-cycle completion pulse to the owner.
- `err`  out  1  one-cycle pulse when the watchdog aborts.
- `busy`  out  1  high in any state other than IDLE.

## Operation

States: IDLE, LOAD, RUN, DONE, ERR.
- **IDLE:**
  - If any `req` is high, pick the winner, latch its `mode`/`d`/`n` into internal registers and go to LOAD.
  - Arbitration: with one request, it wins. With both, the requester not served last wins.
  - `last` pointer resets to 1, so `req0` wins the first contention.
- **LOAD:** `cnt_enable`=1, `cnt_mode`=`LOAD_MODE`, `cnt_D`=latched d. Next state is RUN if latched n≠0, otherwise DONE.
- **RUN:**
  - Drives `cnt_enable`=1, `cnt_mode`=latched mode, `cnt_D`=latched d.
  - The 4-bit pulse counter increments on every cycle `cnt_rco`=1.
  - When the incremented value equals n, the next state is DONE.
  - The cycle counter increments every RUN cycle. When it reaches `TIMEOUT` without completion, the next state is ERR.
  - If completion and timeout occur in the same cycle, completion wins and the next state is DONE.
- **DONE:** `cnt_enable`=0, `done[owner]`=1, update `last`=owner, go to IDLE.
- **ERR:** `cnt_enable`=0, `done[owner]`=1, `err`=1, update `last`=owner, go to IDLE.
- `grant` is one-hot on the owner in LOAD, RUN, DONE and ERR; it is 2'b00 in IDLE.
- Operands are latched at grant. Later changes on `mode`/`d`/`n`, or `req` being dropped, do not affect the transaction in flight.
- Pulse and cycle counters clear on entry to LOAD.
- IDLE outputs: `cnt_enable`=0, `cnt_mode`=2'b00, `cnt_D`=4'h0.

## Timing

- Reset values: state IDLE, `grant`=0, `done`=0, `err`=0, `busy`=0, `cnt_enable`=0, `cnt_mode`=0, `cnt_D`=0, `last`=1, internal counters 0.
- `reset` asserted in any state returns to IDLE on the next edge, aborting the transaction with no `done` and no `err`.
- Outputs are decoded from registered state and latched operands (Moore).
- Latency: `req` sampled in IDLE at edge k → LOAD during cycle k+1 → RUN from k+2.
- `rco` sampled in RUN at edge m, making the count equal n → DONE during cycle m+1 → IDLE at m+2.
- Load-only (n=0): `req` at edge k → LOAD k+1 → DONE k+2.
- Minimum one IDLE cycle between transactions. A pending request is granted on the edge ending that IDLE cycle.
- `rco` is counted only in RUN; pulses during LOAD, DONE or IDLE are ignored.
- n=15 with 15 pulses completes normally; the pulse counter never wraps because completion occurs first.

## Test plan

- Single request: `req0`, d0=4'h3, mode0=2'b00, n0=2; bench pulses `cnt_rco` on RUN cycles 3 and 7 → LOAD shows `cnt_mode`=2'b11, `cnt_D`=3; `done[0]` one cycle after the second pulse; `grant`=2'b01 throughout.
- Contention: `req0` and `req1` high from reset, each n=1 → req0 served first, then req1 after one IDLE cycle. On the next contention req0 wins again because `last`=1.
- Load-only: `req1`, n1=0, d1=4'hA → one LOAD cycle with `cnt_D`=4'hA, then `done[1]`; RUN never entered.
- Watchdog: `req0`, n0=1, `cnt_rco` held low, TIMEOUT=64 → `err`=1 and `done[0]`=1 in the same cycle, 64 RUN cycles after RUN entry; next state IDLE.
- Simultaneous events: final `rco` on the cycle the timeout is reached → `done` pulses, `err` stays 0.
- Mid-transaction reset: `reset` asserted during RUN → next cycle all outputs at reset values; `done` and `err` never pulse.

Source files
------------

// File: rtl/contador_sched.sv
// contador_sched: round-robin owner arbitration for a shared 4-bit contador.
// A granted requester gets one LOAD cycle of its preset, then a RUN phase in its
// own mode until n rco pulses are seen; a watchdog aborts RUN after TIMEOUT cycles.
module contador_sched #(
   parameter logic [1:0]  LOAD_MODE = 2'b11,
   parameter int unsigned TIMEOUT   = 64
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req0,
   input  logic       req1,
   input  logic [1:0] mode0,
   input  logic [1:0] mode1,
   input  logic [3:0] d0,
   input  logic [3:0] d1,
   input  logic [3:0] n0,
   input  logic [3:0] n1,
   input  logic       cnt_rco,
   output logic       cnt_enable,
   output logic [1:0] cnt_mode,
   output logic [3:0] cnt_D,
   output logic [1:0] grant,
   output logic [1:0] done,
   output logic       err,
   output logic       busy
);

   localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_RUN,
      S_DONE,
      S_ERR
   } state_t;

   state_t     r_state;
   state_t     w_next;
   logic       r_owner;
   logic       r_last;
   logic [1:0] r_mode;
   logic [3:0] r_d;
   logic [3:0] r_n;
   logic [3:0] r_pulse;
   logic [7:0] r_cyc;

   logic       w_winner;
   logic [3:0] w_pulse_inc;
   logic [7:0] w_cyc_inc;
   logic       w_hit;
   logic       w_tmo;
   logic [1:0] w_onehot;

   // Arbitration and RUN-phase progress terms.
   always_comb begin
      // On contention the requester not served last wins; otherwise the lone requester.
      w_winner    = (req0 && req1) ? ~r_last : req1;
      w_pulse_inc = r_pulse + {3'b000, cnt_rco};
      w_hit       = cnt_rco && (w_pulse_inc == r_n);
      w_cyc_inc   = r_cyc + 8'd1;
      w_tmo       = (w_cyc_inc == TIMEOUT_C);
      w_onehot    = r_owner ? 2'b10 : 2'b01;
   end

   // Next-state decode; completion takes priority over the watchdog.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (req0 || req1) w_next = S_LOAD;
         S_LOAD:  w_next = (r_n != 4'd0) ? S_RUN : S_DONE;
         S_RUN: begin
            if (w_hit)      w_next = S_DONE;
            else if (w_tmo) w_next = S_ERR;
         end
         S_DONE:  w_next = S_IDLE;
         S_ERR:   w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // State register plus latched operands, counters and round-robin pointer.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_owner <= 1'b0;
         r_last  <= 1'b1;
         r_mode  <= '0;
         r_d     <= '0;
         r_n     <= '0;
         r_pulse <= '0;
         r_cyc   <= '0;
      end else begin
         r_state <= w_next;
         case (r_state)
            S_IDLE: begin
               if (req0 || req1) begin
                  r_owner <= w_winner;
                  r_mode  <= w_winner ? mode1 : mode0;
                  r_d     <= w_winner ? d1 : d0;
                  r_n     <= w_winner ? n1 : n0;
                  r_pulse <= '0;
                  r_cyc   <= '0;
               end
            end
            S_RUN: begin
               r_pulse <= w_pulse_inc;
               r_cyc   <= w_cyc_inc;
            end
            S_DONE, S_ERR: r_last <= r_owner;
            default: ;
         endcase
      end
   end

   // Moore output decode from the registered state and latched operands.
   always_comb begin
      cnt_enable = 1'b0;
      cnt_mode   = 2'b00;
      cnt_D      = 4'h0;
      grant      = 2'b00;
      done       = 2'b00;
      err        = 1'b0;
      busy       = 1'b0;
      case (r_state)
         S_LOAD: begin
            cnt_enable = 1'b1;
            cnt_mode   = LOAD_MODE;
            cnt_D      = r_d;
            grant      = w_onehot;
            busy       = 1'b1;
         end
         S_RUN: begin
            cnt_enable = 1'b1;
            cnt_mode   = r_mode;
            cnt_D      = r_d;
            grant      = w_onehot;
            busy       = 1'b1;
         end
         S_DONE: begin
            grant = w_onehot;
            done  = w_onehot;
            busy  = 1'b1;
         end
         S_ERR: begin
            grant = w_onehot;
            done  = w_onehot;
            err   = 1'b1;
            busy  = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_contador_sched.sv
// Self-checking bench for contador_sched: directed scenarios plus randomized
// transactions, each compared cycle by cycle against a transaction-level model.
module tb_contador_sched;

   localparam logic [1:0] LM  = 2'b11;
   localparam int         TMO = 64;

   logic       clk = 1'b0;
   logic       reset;
   logic       req0, req1;
   logic [1:0] mode0, mode1;
   logic [3:0] d0, d1, n0, n1;
   logic       cnt_rco;
   logic       cnt_enable;
   logic [1:0] cnt_mode;
   logic [3:0] cnt_D;
   logic [1:0] grant, done;
   logic       err, busy;

   int checks = 0;
   int errors = 0;

   contador_sched #(.LOAD_MODE(LM), .TIMEOUT(TMO)) dut (
      .clk(clk), .reset(reset),
      .req0(req0), .req1(req1),
      .mode0(mode0), .mode1(mode1),
      .d0(d0), .d1(d1), .n0(n0), .n1(n1),
      .cnt_rco(cnt_rco),
      .cnt_enable(cnt_enable), .cnt_mode(cnt_mode), .cnt_D(cnt_D),
      .grant(grant), .done(done), .err(err), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Transaction model: how many RUN cycles a job lasts and whether it aborts.
   function automatic void model(input logic [3:0] n, input logic [255:0] pat,
                                 output int len, output bit e);
      int cnt = 0;
      len = TMO;
      e   = 1'b1;
      if (n == 4'd0) begin
         len = 0;
         e   = 1'b0;
         return;
      end
      for (int i = 0; i < TMO; i++) begin
         if (pat[i]) cnt++;
         if (cnt == int'(n)) begin
            len = i + 1;
            e   = 1'b0;
            return;
         end
      end
   endfunction

   task automatic set_req(input bit w, input logic [1:0] m, input logic [3:0] d,
                          input logic [3:0] n);
      if (w) begin
         req1 = 1'b1; mode1 = m; d1 = d; n1 = n;
      end else begin
         req0 = 1'b1; mode0 = m; d0 = d; n0 = n;
      end
   endtask

   // Follows one granted transaction from the sampling edge to its IDLE cycle.
   task automatic serve(input bit w, input logic [1:0] m, input logic [3:0] d,
                        input logic [3:0] n, input logic [255:0] pat, input string tag);
      int          len;
      bit          e;
      logic [1:0]  g;
      logic [12:0] obs, exp;
      logic [6:0]  o7, e7;
      model(n, pat, len, e);
      g = w ? 2'b10 : 2'b01;
      cnt_rco = 1'($urandom);
      tick();
      obs = {grant, done, err, busy, cnt_enable, cnt_mode, cnt_D};
      exp = {g, 2'b00, 1'b0, 1'b1, 1'b1, LM, d};
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s load: got %h expected %h", tag, obs, exp);
      end
      if (w) begin
         mode1 = 2'($urandom); d1 = 4'($urandom); n1 = 4'($urandom);
      end else begin
         mode0 = 2'($urandom); d0 = 4'($urandom); n0 = 4'($urandom);
      end
      cnt_rco = 1'($urandom);
      for (int i = 0; i < len; i++) begin
         tick();
         obs = {grant, done, err, busy, cnt_enable, cnt_mode, cnt_D};
         exp = {g, 2'b00, 1'b0, 1'b1, 1'b1, m, d};
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL %s run[%0d]: got %h expected %h", tag, i, obs, exp);
         end
         cnt_rco = pat[i];
      end
      tick();
      o7 = {grant, done, err, busy, cnt_enable};
      e7 = {g, g, e, 1'b1, 1'b0};
      checks++;
      if (o7 !== e7) begin
         errors++;
         $display("FAIL %s finish: got %b expected %b", tag, o7, e7);
      end
      if (w) req1 = 1'b0; else req0 = 1'b0;
      cnt_rco = 1'($urandom);
      tick();
      obs = {grant, done, err, busy, cnt_enable, cnt_mode, cnt_D};
      checks++;
      if (obs !== 13'd0) begin
         errors++;
         $display("FAIL %s idle: got %h expected 0000", tag, obs);
      end
      cnt_rco = 1'b0;
   endtask

   task automatic test_reset();
      logic [12:0] obs;
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         obs = {grant, done, err, busy, cnt_enable, cnt_mode, cnt_D};
         checks++;
         if (obs !== 13'd0) begin
            errors++;
            $display("FAIL reset[%0d]: got %h expected 0000", i, obs);
         end
      end
      reset = 1'b0;
   endtask

   task automatic test_contention();
      logic [255:0] p0, p1;
      p0 = '0; p0[1] = 1'b1;
      p1 = '0; p1[0] = 1'b1;
      set_req(0, 2'b01, 4'h5, 4'd1);
      set_req(1, 2'b10, 4'h9, 4'd1);
      serve(0, 2'b01, 4'h5, 4'd1, p0, "cont1_r0");
      serve(1, 2'b10, 4'h9, 4'd1, p1, "cont1_r1");
      set_req(0, 2'b00, 4'h1, 4'd1);
      set_req(1, 2'b11, 4'hE, 4'd1);
      serve(0, 2'b00, 4'h1, 4'd1, p1, "cont2_r0");
      serve(1, 2'b11, 4'hE, 4'd1, p0, "cont2_r1");
      // Serving req0 alone leaves last=0, so req1 must win the next contention.
      set_req(0, 2'b10, 4'h2, 4'd0);
      serve(0, 2'b10, 4'h2, 4'd0, p0, "solo_r0");
      set_req(0, 2'b01, 4'h4, 4'd1);
      set_req(1, 2'b01, 4'h6, 4'd1);
      serve(1, 2'b01, 4'h6, 4'd1, p0, "cont3_r1");
      serve(0, 2'b01, 4'h4, 4'd1, p1, "cont3_r0");
   endtask

   task automatic test_single();
      logic [255:0] p;
      p = '0; p[2] = 1'b1; p[6] = 1'b1;
      set_req(0, 2'b00, 4'h3, 4'd2);
      serve(0, 2'b00, 4'h3, 4'd2, p, "single");
   endtask

   task automatic test_load_only();
      logic [255:0] p;
      p = '1;
      set_req(1, 2'b01, 4'hA, 4'd0);
      serve(1, 2'b01, 4'hA, 4'd0, p, "load_only");
   endtask

   task automatic test_watchdog();
      set_req(0, 2'b10, 4'h7, 4'd1);
      serve(0, 2'b10, 4'h7, 4'd1, '0, "watchdog");
   endtask

   task automatic test_simultaneous();
      logic [255:0] p;
      p = '0; p[10] = 1'b1; p[40] = 1'b1; p[TMO-1] = 1'b1;
      set_req(1, 2'b11, 4'hC, 4'd3);
      serve(1, 2'b11, 4'hC, 4'd3, p, "simultaneous");
   endtask

   task automatic test_n15();
      logic [255:0] p;
      p = '0;
      for (int i = 3; i < 60; i += 4) p[i] = 1'b1;
      set_req(0, 2'b01, 4'hF, 4'd15);
      serve(0, 2'b01, 4'hF, 4'd15, p, "n15");
   endtask

   task automatic test_random();
      logic [255:0] p;
      bit           w;
      logic [1:0]   m;
      logic [3:0]   d, n;
      int           dens;
      for (int t = 0; t < 20; t++) begin
         w    = 1'($urandom);
         m    = 2'($urandom);
         d    = 4'($urandom);
         n    = 4'($urandom);
         dens = $urandom_range(1, 8);
         p    = '0;
         for (int i = 0; i < TMO; i++) p[i] = ($urandom_range(0, dens) == 0);
         set_req(w, m, d, n);
         serve(w, m, d, n, p, "random");
      end
   endtask

   task automatic test_mid_reset();
      logic [12:0]  obs;
      logic [255:0] p;
      set_req(0, 2'b01, 4'h8, 4'd5);
      tick();
      cnt_rco = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      reset = 1'b1;
      req0  = 1'b0;
      cnt_rco = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         obs = {grant, done, err, busy, cnt_enable, cnt_mode, cnt_D};
         checks++;
         if (obs !== 13'd0) begin
            errors++;
            $display("FAIL mid_reset[%0d]: got %h expected 0000", i, obs);
         end
      end
      reset = 1'b0;
      tick();
      obs = {grant, done, err, busy, cnt_enable, cnt_mode, cnt_D};
      checks++;
      if (obs !== 13'd0) begin
         errors++;
         $display("FAIL mid_reset_exit: got %h expected 0000", obs);
      end
      // The round-robin pointer is back at 1, so req0 wins again.
      p = '0; p[0] = 1'b1;
      set_req(0, 2'b10, 4'hB, 4'd1);
      set_req(1, 2'b00, 4'hD, 4'd1);
      serve(0, 2'b10, 4'hB, 4'd1, p, "post_reset_r0");
      serve(1, 2'b00, 4'hD, 4'd1, p, "post_reset_r1");
   endtask

   initial begin
      reset = 1'b1;
      req0 = 1'b0; req1 = 1'b0;
      mode0 = '0; mode1 = '0;
      d0 = '0; d1 = '0; n0 = '0; n1 = '0;
      cnt_rco = 1'b0;
      test_reset();
      test_contention();
      test_single();
      test_load_only();
      test_watchdog();
      test_simultaneous();
      test_n15();
      test_random();
      test_mid_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
